// File: rtl/systolic_ctrl.sv
// Step sequencer for an N x N systolic MAC array: broadcasts the per-step start
// strobe, waits on every cell's done flag and drives skewed edge-buffer addresses.
module systolic_ctrl #(
    parameter int N       = 4,
    parameter int K_MAX   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       k_len,
    input  logic [N*N-1:0]    mac_done,
    output logic              mac_st,
    output logic              acc_clr,
    output logic [N*AW-1:0]   row_addr,
    output logic [N-1:0]      row_valid,
    output logic [N*AW-1:0]   col_addr,
    output logic [N-1:0]      col_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SW = $clog2(K_MAX + 2 * N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   L_KMAX     = K_MAX[AW:0];
    localparam logic [SW:0]   L_SKEW_EXT = (SW + 1)'(2 * (N - 1));
    localparam logic [SW:0]   L_ONE_EXT  = (SW + 1)'(1);
    localparam logic [SW-1:0] L_S_ONE    = SW'(1);
    localparam logic [TW-1:0] L_WD_ONE   = TW'(1);
    localparam logic [TW-1:0] L_WD_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_ISSUE   = 3'd2,
        S_MASK    = 3'd3,
        S_WAIT    = 3'd4,
        S_RELEASE = 3'd5,
        S_FIN     = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_s, w_s_nxt;
    logic [AW:0]     r_k, w_k_nxt;
    logic [TW-1:0]   r_wd, w_wd_nxt;
    logic            w_accept, w_all_done, w_last;

    logic            w_mac_st_nxt, w_acc_clr_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic [N*AW-1:0] w_addr_nxt;
    logic [N-1:0]    w_valid_nxt;
    logic [AW:0]     w_lane;

    logic            r_mac_st, r_acc_clr, r_busy, r_done, r_err;
    logic [N*AW-1:0] r_row_addr, r_col_addr;
    logic [N-1:0]    r_row_valid, r_col_valid;

    // Lane index s - lane in signed arithmetic so lanes not yet reached stay invalid.
    function automatic logic [AW:0] skew_lane(input logic [SW-1:0] s, input logic [AW:0] k,
                                              input int lane);
        int d;
        d = int'(s) - lane;
        if ((d >= 32'sd0) && (d < int'(k))) begin
            skew_lane = {1'b1, d[AW-1:0]};
        end else begin
            skew_lane = {(AW + 1){1'b0}};
        end
    endfunction

    assign w_accept   = start && (k_len != {(AW + 1){1'b0}}) && (k_len <= L_KMAX);
    assign w_all_done = &mac_done;
    assign w_last     = ({1'b0, SW'(r_k)} + L_SKEW_EXT) == ({1'b0, r_s} + L_ONE_EXT);

    // State, step index, latched length and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_s     <= {SW{1'b0}};
            r_k     <= {(AW + 1){1'b0}};
            r_wd    <= {TW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_k     <= w_k_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Next-state logic; all-done is tested before the watchdog so it wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_k_nxt     = r_k;
        w_wd_nxt    = r_wd;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (w_accept) begin
                    w_state_nxt = S_CLR;
                    w_k_nxt     = k_len;
                    w_s_nxt     = {SW{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_CLR:   w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_MASK;
            S_MASK: begin
                w_state_nxt = S_WAIT;
                w_wd_nxt    = {TW{1'b0}};
            end
            S_WAIT: begin
                if (w_all_done) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_wd == L_WD_LAST) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wd_nxt = r_wd + L_WD_ONE;
                end
            end
            S_RELEASE: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_ISSUE;
                    w_s_nxt     = r_s + L_S_ONE;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight off a flop.
    always_comb begin
        w_lane        = {(AW + 1){1'b0}};
        w_addr_nxt    = {(N * AW){1'b0}};
        w_valid_nxt   = {N{1'b0}};
        w_mac_st_nxt  = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_MASK) ||
                        (w_state_nxt == S_WAIT);
        w_acc_clr_nxt = (w_state_nxt == S_CLR);
        w_done_nxt    = (w_state_nxt == S_FIN);
        w_err_nxt     = (w_state_nxt == S_ERR);
        w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
        if (w_mac_st_nxt || (w_state_nxt == S_RELEASE)) begin
            for (int r = 0; r < N; r++) begin
                w_lane                  = skew_lane(w_s_nxt, w_k_nxt, r);
                w_valid_nxt[r]          = w_lane[AW];
                w_addr_nxt[r*AW +: AW]  = w_lane[AW-1:0];
            end
        end else begin
            w_addr_nxt  = {(N * AW){1'b0}};
            w_valid_nxt = {N{1'b0}};
        end
    end

    // Output registers; rows and columns share the same skew rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_st    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_row_addr  <= {(N * AW){1'b0}};
            r_col_addr  <= {(N * AW){1'b0}};
            r_row_valid <= {N{1'b0}};
            r_col_valid <= {N{1'b0}};
        end else begin
            r_mac_st    <= w_mac_st_nxt;
            r_acc_clr   <= w_acc_clr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_row_addr  <= w_addr_nxt;
            r_col_addr  <= w_addr_nxt;
            r_row_valid <= w_valid_nxt;
            r_col_valid <= w_valid_nxt;
        end
    end

    assign mac_st    = r_mac_st;
    assign acc_clr   = r_acc_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign row_addr  = r_row_addr;
    assign col_addr  = r_col_addr;
    assign row_valid = r_row_valid;
    assign col_valid = r_col_valid;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with N=2, K_MAX=16, AW=4, TIMEOUT=8 and a
// small behavioural cell-array model driving mac_done.
module tb_systolic_ctrl;

    localparam int MODE_MODEL = 0;
    localparam int MODE_ONES  = 1;
    localparam int MODE_STUCK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] k_len;
    logic [3:0] mac_done;
    logic       mac_st, acc_clr, busy, done, err;
    logic [7:0] row_addr, col_addr;
    logic [1:0] row_valid, col_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cell_mode = MODE_MODEL;

    logic [1:0] cap_rv [0:31];
    logic [7:0] cap_ra [0:31];
    logic [1:0] cap_cv [0:31];
    logic [7:0] cap_ca [0:31];

    typedef struct {
        logic [4:0] k;
        int         mode;
        bit         accept;
        int         steps;
        int         cycles;
        int         poke;
        bit         skew;
    } job_t;

    typedef struct {
        logic [1:0] rv;
        logic [7:0] ra;
        logic [1:0] cv;
        logic [7:0] ca;
    } skew_t;

    job_t  jobs [8];
    skew_t skews [5];

    systolic_ctrl #(.N(2), .K_MAX(16), .AW(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .mac_done(mac_done),
        .mac_st(mac_st), .acc_clr(acc_clr), .row_addr(row_addr), .row_valid(row_valid),
        .col_addr(col_addr), .col_valid(col_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cell array model: done drops on a mac_st rise and returns two edges later.
    logic cell_done = 1'b0;
    logic cell_prev = 1'b0;
    logic cell_cnt  = 1'b0;
    always @(posedge clk) begin
        cell_prev <= mac_st;
        if (mac_st && !cell_prev) begin
            cell_done <= 1'b0;
            cell_cnt  <= 1'b1;
        end else if (cell_cnt) begin
            cell_done <= 1'b1;
            cell_cnt  <= 1'b0;
        end
    end
    assign mac_done = (cell_mode == MODE_ONES)  ? 4'b1111 :
                      (cell_mode == MODE_STUCK) ? ({4{cell_done}} & 4'b1110) : {4{cell_done}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, mac_st, acc_clr, row_addr, row_valid, col_addr, col_valid, busy, done, err};
    endfunction

    // Launch one job and observe it cycle by cycle, counting from the CLR cycle (cyc=1).
    task automatic run_job(input logic [4:0] k, input int poke, input int budget,
                           output int cyc, output int n_clr, output int n_done,
                           output int n_steps, output int gap_bad, output int unstable,
                           output int n_err);
        logic prev_st;
        logic rise;
        int   gap;
        cyc = 0; n_clr = 0; n_done = 0; n_steps = 0; gap_bad = 0; unstable = 0; n_err = 0;
        prev_st = 1'b0;
        gap = -1;
        @(negedge clk);
        start = 1'b1;
        k_len = k;
        while (cyc < budget) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            rise = mac_st && !prev_st;
            if (acc_clr) n_clr++;
            if (err) n_err++;
            if (rise) begin
                if (gap >= 0 && gap != 1) gap_bad++;
                gap = -1;
                if (n_steps < 32) begin
                    cap_rv[n_steps] = row_valid;
                    cap_ra[n_steps] = row_addr;
                    cap_cv[n_steps] = col_valid;
                    cap_ca[n_steps] = col_addr;
                end
                n_steps++;
            end else begin
                if (!mac_st && prev_st) gap = 1;
                else if (!mac_st && gap >= 1) gap++;
                if (busy && !acc_clr && !done && n_steps > 0 && n_steps <= 32) begin
                    if (row_valid !== cap_rv[n_steps-1] || row_addr !== cap_ra[n_steps-1] ||
                        col_valid !== cap_cv[n_steps-1] || col_addr !== cap_ca[n_steps-1])
                        unstable++;
                end
            end
            prev_st = mac_st;
            if (poke == cyc) begin
                start = 1'b1;
                k_len = 5'd5;
            end
            if (done) begin
                n_done++;
                break;
            end
            if (err) break;
        end
    endtask

    int cyc, n_clr, n_done, n_steps, gap_bad, unstable, n_err;

    initial begin
        jobs[0] = '{5'd3,  MODE_MODEL, 1'b1, 5,  22, -1, 1'b1};
        jobs[1] = '{5'd3,  MODE_ONES,  1'b1, 5,  22, -1, 1'b0};
        jobs[2] = '{5'd0,  MODE_MODEL, 1'b0, 0,  0,  -1, 1'b0};
        jobs[3] = '{5'd17, MODE_MODEL, 1'b0, 0,  0,  -1, 1'b0};
        jobs[4] = '{5'd3,  MODE_MODEL, 1'b1, 5,  22, 7,  1'b0};
        jobs[5] = '{5'd3,  MODE_ONES,  1'b1, 5,  22, 22, 1'b0};
        jobs[6] = '{5'd1,  MODE_ONES,  1'b1, 3,  14, -1, 1'b0};
        jobs[7] = '{5'd16, MODE_ONES,  1'b1, 18, 74, -1, 1'b0};
        skews[0] = '{2'b01, 8'h00, 2'b01, 8'h00};
        skews[1] = '{2'b11, 8'h01, 2'b11, 8'h01};
        skews[2] = '{2'b11, 8'h12, 2'b11, 8'h12};
        skews[3] = '{2'b10, 8'h20, 2'b10, 8'h20};
        skews[4] = '{2'b00, 8'h00, 2'b00, 8'h00};

        rst_n = 1'b0;
        start = 1'b0;
        k_len = 5'd0;
        #2;
        check("reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cell_mode = jobs[i].mode;
            if (jobs[i].accept) begin
                run_job(jobs[i].k, jobs[i].poke, 120, cyc, n_clr, n_done, n_steps,
                        gap_bad, unstable, n_err);
                check($sformatf("job%0d_cycles", i), cyc, jobs[i].cycles);
                check($sformatf("job%0d_steps", i), n_steps, jobs[i].steps);
                check($sformatf("job%0d_acc_clr", i), n_clr, 1);
                check($sformatf("job%0d_done", i), n_done, 1);
                check($sformatf("job%0d_gap", i), gap_bad, 0);
                check($sformatf("job%0d_stable", i), unstable, 0);
                check($sformatf("job%0d_err", i), n_err, 0);
                @(negedge clk);
                start = 1'b0;
                check($sformatf("job%0d_after", i), {busy, done, acc_clr}, 3'b000);
                @(negedge clk);
                check($sformatf("job%0d_idle", i), {busy, acc_clr}, 2'b00);
                if (jobs[i].skew) begin
                    for (int s = 0; s < 5; s++) begin
                        check($sformatf("skew_row_valid_s%0d", s), cap_rv[s], skews[s].rv);
                        check($sformatf("skew_row_addr_s%0d", s), cap_ra[s], skews[s].ra);
                        check($sformatf("skew_col_valid_s%0d", s), cap_cv[s], skews[s].cv);
                        check($sformatf("skew_col_addr_s%0d", s), cap_ca[s], skews[s].ca);
                    end
                end
            end else begin
                n_clr = 0;
                n_steps = 0;
                @(negedge clk);
                start = 1'b1;
                k_len = jobs[i].k;
                @(negedge clk);
                start = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (busy) n_steps++;
                    if (acc_clr) n_clr++;
                    @(negedge clk);
                end
                check($sformatf("reject%0d_busy", i), n_steps, 0);
                check($sformatf("reject%0d_acc_clr", i), n_clr, 0);
            end
        end

        // Watchdog: one cell never answers.
        cell_mode = MODE_STUCK;
        run_job(5'd3, -1, 40, cyc, n_clr, n_done, n_steps, gap_bad, unstable, n_err);
        check("wd_cycle_of_err", cyc, 12);
        check("wd_err", err, 1);
        check("wd_mac_st_busy", {mac_st, busy}, 2'b00);
        check("wd_no_done", n_done, 0);
        check("wd_steps", n_steps, 1);
        check("wd_zero_addr", {row_valid, row_addr, col_valid, col_addr}, 20'd0);
        repeat (3) @(negedge clk);
        check("wd_err_held", {err, busy, mac_st}, 3'b100);
        cell_mode = MODE_MODEL;
        run_job(5'd2, -1, 60, cyc, n_clr, n_done, n_steps, gap_bad, unstable, n_err);
        check("wd_recover_cycles", cyc, 18);
        check("wd_recover_done", n_done, 1);
        check("wd_recover_err_clear", n_err, 0);
        @(negedge clk);
        check("wd_recover_after", {err, busy}, 2'b00);

        // Asynchronous reset during WAIT of step 2.
        begin
            logic prev;
            int   rises;
            int   since;
            bit   hit;
            prev = 1'b0; rises = 0; since = 0; hit = 1'b0;
            @(negedge clk);
            start = 1'b1;
            k_len = 5'd3;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 40 && !hit; c++) begin
                @(negedge clk);
                if (mac_st && !prev) begin
                    rises++;
                    since = 0;
                end else begin
                    since++;
                end
                prev = mac_st;
                if (rises == 3 && since == 2) hit = 1'b1;
            end
            check("rst_reached_wait", hit, 1);
            check("rst_pre_mac_st", mac_st, 1);
            rst_n = 1'b0;
            #1;
            check("rst_async_outputs", all_outs(), 32'd0);
            n_done = 0;
            repeat (2) begin
                @(negedge clk);
                if (done) n_done++;
            end
            check("rst_no_done", n_done, 0);
            rst_n = 1'b1;
        end
        run_job(5'd2, -1, 60, cyc, n_clr, n_done, n_steps, gap_bad, unstable, n_err);
        check("post_rst_cycles", cyc, 18);
        check("post_rst_steps", n_steps, 4);
        check("post_rst_done", n_done, 1);
        check("post_rst_s0", {cap_rv[0], cap_ra[0]}, {2'b01, 8'h00});
        check("post_rst_s1", {cap_rv[1], cap_ra[1]}, {2'b11, 8'h01});
        check("post_rst_s2", {cap_rv[2], cap_ra[2]}, {2'b10, 8'h10});
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
